// File: rtl/canvas_feature_extractor.sv
// Streams a CANVAS_W x CANVAS_H 1-bit canvas from memory and accumulates pixel count,
// bounding box and a GRID x GRID occupancy signature, presented with valid/ready.
module canvas_feature_extractor #(
  parameter int CANVAS_W     = 32,
  parameter int CANVAS_H     = 32,
  parameter int GRID         = 4,
  parameter int CELL_THRESH  = 4,
  parameter int READ_LATENCY = 1,
  localparam int AW   = $clog2(CANVAS_W * CANVAS_H),
  localparam int CNTW = $clog2(CANVAS_W * CANVAS_H + 1),
  localparam int XW   = $clog2(CANVAS_W),
  localparam int YW   = $clog2(CANVAS_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_start,
  output logic [AW-1:0]        read_addr,
  output logic                 read_enable,
  input  logic                 read_data,
  output logic                 pending,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [CNTW-1:0]      pix_count,
  output logic [XW-1:0]        bbox_xmin,
  output logic [XW-1:0]        bbox_xmax,
  output logic [YW-1:0]        bbox_ymin,
  output logic [YW-1:0]        bbox_ymax,
  output logic                 empty,
  output logic [GRID*GRID-1:0] grid_bits
);

  localparam int N         = CANVAS_W * CANVAS_H;
  localparam int CELL_W    = CANVAS_W / GRID;
  localparam int CELL_H    = CANVAS_H / GRID;
  localparam int CELL_SIZE = CELL_W * CELL_H;
  localparam int CCW       = $clog2(CELL_SIZE + 1);
  localparam int NCELL     = GRID * GRID;
  localparam int GW        = (GRID > 1) ? $clog2(GRID) : 1;
  localparam int SXW       = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int SYW       = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam int LW        = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t state;

  // Issue-side coordinates track read_addr; sub-cell counters avoid any division
  logic [XW-1:0]  x_cnt;
  logic [YW-1:0]  y_cnt;
  logic [SXW-1:0] xs_cnt;
  logic [SYW-1:0] ys_cnt;
  logic [GW-1:0]  col_cnt;
  logic [GW-1:0]  row_cnt;
  logic [LW-1:0]  drain_cnt;

  logic [READ_LATENCY-1:0]          dl_valid;
  logic [READ_LATENCY-1:0][XW-1:0]  dl_x;
  logic [READ_LATENCY-1:0][YW-1:0]  dl_y;
  logic [READ_LATENCY-1:0][GW-1:0]  dl_col;
  logic [READ_LATENCY-1:0][GW-1:0]  dl_row;

  logic [CNTW-1:0]            acc_count, nxt_count;
  logic [XW-1:0]              acc_xmin, acc_xmax, nxt_xmin, nxt_xmax;
  logic [YW-1:0]              acc_ymin, acc_ymax, nxt_ymin, nxt_ymax;
  logic [NCELL-1:0][CCW-1:0]  acc_cell, nxt_cell;
  logic [NCELL-1:0]           nxt_grid;

  logic          s_hit;
  logic [XW-1:0] s_x;
  logic [YW-1:0] s_y;
  int            s_cell;

  assign s_hit  = dl_valid[READ_LATENCY-1] & read_data;
  assign s_x    = dl_x[READ_LATENCY-1];
  assign s_y    = dl_y[READ_LATENCY-1];
  assign s_cell = int'(dl_row[READ_LATENCY-1]) * GRID + int'(dl_col[READ_LATENCY-1]);

  // Delay line pairs each issued coordinate with the pixel that returns for it
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_valid <= '0;
      dl_x     <= '0;
      dl_y     <= '0;
      dl_col   <= '0;
      dl_row   <= '0;
    end else begin
      dl_valid[0] <= read_enable;
      dl_x[0]     <= x_cnt;
      dl_y[0]     <= y_cnt;
      dl_col[0]   <= col_cnt;
      dl_row[0]   <= row_cnt;
      for (int i = 1; i < READ_LATENCY; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_x[i]     <= dl_x[i-1];
        dl_y[i]     <= dl_y[i-1];
        dl_col[i]   <= dl_col[i-1];
        dl_row[i]   <= dl_row[i-1];
      end
    end
  end

  // Accumulator values including the sample on read_data this cycle, so the
  // final sample can be folded in on the same edge that registers the result
  always_comb begin
    nxt_count = acc_count;
    nxt_xmin  = acc_xmin;
    nxt_xmax  = acc_xmax;
    nxt_ymin  = acc_ymin;
    nxt_ymax  = acc_ymax;
    nxt_cell  = acc_cell;
    nxt_grid  = '0;
    if (s_hit) begin
      nxt_count = acc_count + 1'b1;
      if (s_x < acc_xmin) nxt_xmin = s_x;
      if (s_x > acc_xmax) nxt_xmax = s_x;
      if (s_y < acc_ymin) nxt_ymin = s_y;
      if (s_y > acc_ymax) nxt_ymax = s_y;
    end
    for (int i = 0; i < NCELL; i++) begin
      if (s_hit && s_cell == i && acc_cell[i] != CCW'(CELL_SIZE))
        nxt_cell[i] = acc_cell[i] + 1'b1;
      nxt_grid[i] = 32'(nxt_cell[i]) >= 32'(CELL_THRESH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      read_enable  <= 1'b0;
      read_addr    <= '0;
      pending      <= 1'b0;
      result_valid <= 1'b0;
      empty        <= 1'b0;
      pix_count    <= '0;
      bbox_xmin    <= '0;
      bbox_xmax    <= '0;
      bbox_ymin    <= '0;
      bbox_ymax    <= '0;
      grid_bits    <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      xs_cnt       <= '0;
      ys_cnt       <= '0;
      col_cnt      <= '0;
      row_cnt      <= '0;
      drain_cnt    <= '0;
      acc_count    <= '0;
      acc_xmin     <= '0;
      acc_xmax     <= '0;
      acc_ymin     <= '0;
      acc_ymax     <= '0;
      acc_cell     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_start) begin
            state       <= SCAN;
            pending     <= 1'b1;
            read_enable <= 1'b1;
            read_addr   <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            xs_cnt      <= '0;
            ys_cnt      <= '0;
            col_cnt     <= '0;
            row_cnt     <= '0;
            acc_count   <= '0;
            acc_xmin    <= XW'(CANVAS_W - 1);
            acc_xmax    <= '0;
            acc_ymin    <= YW'(CANVAS_H - 1);
            acc_ymax    <= '0;
            acc_cell    <= '0;
          end
        end
        SCAN: begin
          acc_count <= nxt_count;
          acc_xmin  <= nxt_xmin;
          acc_xmax  <= nxt_xmax;
          acc_ymin  <= nxt_ymin;
          acc_ymax  <= nxt_ymax;
          acc_cell  <= nxt_cell;
          if (read_addr == AW'(N - 1)) begin
            state       <= DRAIN;
            read_enable <= 1'b0;
            read_addr   <= '0;
            drain_cnt   <= '0;
          end else begin
            read_addr <= read_addr + 1'b1;
            if (x_cnt == XW'(CANVAS_W - 1)) begin
              x_cnt   <= '0;
              xs_cnt  <= '0;
              col_cnt <= '0;
              y_cnt   <= y_cnt + 1'b1;
              if (ys_cnt == SYW'(CELL_H - 1)) begin
                ys_cnt  <= '0;
                row_cnt <= row_cnt + 1'b1;
              end else begin
                ys_cnt <= ys_cnt + 1'b1;
              end
            end else begin
              x_cnt <= x_cnt + 1'b1;
              if (xs_cnt == SXW'(CELL_W - 1)) begin
                xs_cnt  <= '0;
                col_cnt <= col_cnt + 1'b1;
              end else begin
                xs_cnt <= xs_cnt + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          acc_count <= nxt_count;
          acc_xmin  <= nxt_xmin;
          acc_xmax  <= nxt_xmax;
          acc_ymin  <= nxt_ymin;
          acc_ymax  <= nxt_ymax;
          acc_cell  <= nxt_cell;
          if (drain_cnt == LW'(READ_LATENCY - 1)) begin
            state        <= DONE;
            result_valid <= 1'b1;
            pix_count    <= nxt_count;
            if (nxt_count == '0) begin
              empty     <= 1'b1;
              bbox_xmin <= '0;
              bbox_xmax <= '0;
              bbox_ymin <= '0;
              bbox_ymax <= '0;
              grid_bits <= '0;
            end else begin
              empty     <= 1'b0;
              bbox_xmin <= nxt_xmin;
              bbox_xmax <= nxt_xmax;
              bbox_ymin <= nxt_ymin;
              bbox_ymax <= nxt_ymax;
              grid_bits <= nxt_grid;
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            pending      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
